dense_bias_loader: RTL and testbench

DENSE_BIAS_LOADER -- requirements
Module: dense_bias_loader

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/dense_bias_loader_if.sv | 33 +++
 rtl/byte_word_packer.sv | 72 +++++++
 rtl/dense_biases_ram.sv | 27 ++
 rtl/dense_bias_loader.sv | 113 +++++++++++
 tb/tb_dense_bias_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and write-beat type for the bias loading path.
// No logic of its own; consumed by the loader, the byte packer and the bias RAM.
// Defaults here are instance-overridable through the module parameters.
package cnn_pkg;

    localparam int NUM_BIASES     = 10;
    localparam int BYTES_PER_WORD = 4;
    localparam int BIAS_W         = 32;
    localparam int ADDR_W         = 4;

    // Loader FSM encoding, kept as plain constants so legacy tools can read it.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // One bias RAM write: address and assembled word travel together.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BIAS_W-1:0] data;
    } bias_wr_t;

endpackage

// File: rtl/dense_bias_loader_if.sv
// Byte stream, bias RAM write port and consumer read port of the bias loader.
// Pure wiring, no latency.
// Byte stream uses valid/ready; write and read ports have no backpressure.
interface dense_bias_loader_if;
    import cnn_pkg::*;

    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;

    logic [ADDR_W-1:0] wr_addr;
    logic [BIAS_W-1:0] wr_data;
    logic              wr_en;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic              rd_valid;
    logic              rd_err;

    // Loader side.
    modport master (
        input  byte_in, byte_valid, rd_req, rd_idx,
        output byte_ready, wr_addr, wr_data, wr_en, ram_rd_addr, rd_valid, rd_err
    );

    // Host / consumer / RAM side.
    modport slave (
        output byte_in, byte_valid, rd_req, rd_idx,
        input  byte_ready, wr_addr, wr_data, wr_en, ram_rd_addr, rd_valid, rd_err
    );

endinterface

// File: rtl/byte_word_packer.sv
// Assembles little-endian bytes into bias words and emits one write per word.
// Latency: write strobe one cycle after the last byte of a word is taken.
// No backpressure of its own; bytes arriving after the final word are ignored.
module byte_word_packer
    import cnn_pkg::*;
#(
    parameter int NUM_BIASES     = cnn_pkg::NUM_BIASES,
    parameter int BYTES_PER_WORD = cnn_pkg::BYTES_PER_WORD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_vld,
    input  logic [7:0] in_dat,
    output logic       wr_en,
    output bias_wr_t   wr_beat
);

    localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int WCW = ADDR_W + 1;
    localparam logic [BCW-1:0] LAST_BYTE  = BCW'(BYTES_PER_WORD - 1);
    localparam logic [WCW-1:0] WORD_LIMIT = WCW'(NUM_BIASES);

    logic [BCW-1:0]    byte_cnt;
    logic [WCW-1:0]    word_cnt;
    logic [BIAS_W-1:0] asm_q;
    logic [BIAS_W-1:0] word_next;
    logic              take;
    logic              last;

    // Once every word has been written, further bytes must not reach the RAM.
    assign take = in_vld && (word_cnt != WORD_LIMIT);
    assign last = take && (byte_cnt == LAST_BYTE);

    // Drop the incoming byte into its lane on top of what is already assembled.
    always_comb begin
        word_next = asm_q;
        word_next[{byte_cnt, 3'b000} +: 8] = in_dat;
    end

    // Byte/word counters, assembly register and the registered write beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            asm_q    <= '0;
            wr_en    <= 1'b0;
            wr_beat  <= '0;
        end else if (clr) begin
            // Clearing also kills a write that the same cycle's byte would schedule.
            byte_cnt <= '0;
            word_cnt <= '0;
            asm_q    <= '0;
            wr_en    <= 1'b0;
        end else begin
            wr_en <= last;
            if (take) begin
                if (last) begin
                    byte_cnt     <= '0;
                    asm_q        <= '0;
                    word_cnt     <= word_cnt + 1'b1;
                    wr_beat.addr <= word_cnt[ADDR_W-1:0];
                    wr_beat.data <= word_next;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    asm_q    <= word_next;
                end
            end
        end
    end

endmodule

// File: rtl/dense_biases_ram.sv
// Bias storage RAM: one write port, one read port.
// Latency: read data registered, one cycle after the address.
// No backpressure; a write and a read may occur every cycle.
module dense_biases_ram
    import cnn_pkg::*;
#(
    parameter int DEPTH = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BIAS_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BIAS_W-1:0] rd_data
);

    logic [BIAS_W-1:0] mem [DEPTH];

    // Synchronous write and registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dense_bias_loader.sv
// Loads NUM_BIASES bias words from a byte stream into the bias RAM and gates consumer reads.
// Latency: write one cycle after a word's last byte; rd_valid/rd_err one cycle after rd_req.
// byte_ready is high only while loading; reads are never stalled, only accepted or rejected.
module dense_bias_loader
    import cnn_pkg::*;
#(
    parameter int NUM_BIASES     = cnn_pkg::NUM_BIASES,
    parameter int BYTES_PER_WORD = cnn_pkg::BYTES_PER_WORD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    dense_bias_loader_if.master         bus,
    output logic                        busy,
    output logic                        done,
    output logic                        loaded
);

    localparam int WCW = ADDR_W + 1;

    logic [1:0] state;
    logic       loaded_q;
    logic       rd_valid_q;
    logic       rd_err_q;
    logic       start_go;
    logic       abort_go;
    logic       byte_take;
    logic       pk_wr_en;
    logic       wr_fire;
    logic       last_wr;
    logic       rd_ok;
    bias_wr_t   pk_beat;

    assign start_go  = (state == ST_IDLE) && start;
    assign abort_go  = (state == ST_LOAD) && abort;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FINISH);
    assign loaded    = loaded_q;

    assign bus.byte_ready = (state == ST_LOAD);
    assign byte_take      = bus.byte_valid && bus.byte_ready;

    // An abort also masks a write that is on the port in the abort cycle itself.
    assign wr_fire     = pk_wr_en && !abort_go;
    assign last_wr     = wr_fire && (pk_beat.addr == ADDR_W'(NUM_BIASES - 1));
    assign bus.wr_en   = wr_fire;
    assign bus.wr_addr = pk_beat.addr;
    assign bus.wr_data = pk_beat.data;

    byte_word_packer #(
        .NUM_BIASES     (NUM_BIASES),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_go || abort_go),
        .in_vld  (byte_take),
        .in_dat  (bus.byte_in),
        .wr_en   (pk_wr_en),
        .wr_beat (pk_beat)
    );

    // Load sequencing: FINISH follows the cycle that writes the final word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            loaded_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        loaded_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (last_wr) begin
                        state    <= ST_FINISH;
                        loaded_q <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The RAM is addressed straight from the consumer index; only the verdict is registered.
    assign bus.ram_rd_addr = bus.rd_idx;
    assign rd_ok = loaded_q && !busy && (WCW'(bus.rd_idx) < WCW'(NUM_BIASES));

    // Read verdict lines up with the RAM's one-cycle read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req && rd_ok;
            rd_err_q   <= bus.rd_req && !rd_ok;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;

endmodule

// File: tb/tb_dense_bias_loader.sv
// Scoreboard bench for dense_bias_loader with the bias RAM attached.
// Stimulus pushes expected writes/reads; a monitor pops them as the DUT presents them.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_dense_bias_loader;
    import cnn_pkg::*;

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        loaded;
    logic [31:0] ram_rd_data;

    dense_bias_loader_if bus();

    dense_bias_loader dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .loaded (loaded)
    );

    dense_biases_ram ram (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (bus.ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Hand-computed words for bytes 0x00..0x27, little-endian.
    logic [31:0] exp_words [10] = '{
        32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110,
        32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C, 32'h23222120, 32'h27262524
    };

    bias_wr_t exp_wr [$];
    rd_exp_t  exp_rd [$];
    bias_wr_t mw;
    rd_exp_t  mr;

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int last_wr_cyc = -1;
    int exp_spacing = 0;
    int done_cnt    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start          = 1'b0;
        abort          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        bus.rd_req     = 1'b0;
        bus.rd_idx     = 4'd0;
    endtask

    task automatic check_reset_outputs();
        check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_wr_en",      64'(bus.wr_en),      64'd0);
        check("rst_wr_addr",    64'(bus.wr_addr),    64'd0);
        check("rst_wr_data",    64'(bus.wr_data),    64'd0);
        check("rst_busy",       64'(busy),           64'd0);
        check("rst_done",       64'(done),           64'd0);
        check("rst_loaded",     64'(loaded),         64'd0);
        check("rst_rd_valid",   64'(bus.rd_valid),   64'd0);
        check("rst_rd_err",     64'(bus.rd_err),     64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
    endtask

    task automatic push_words(input int count);
        bias_wr_t w;
        for (int k = 0; k < count; k++) begin
            w.addr = 4'(k);
            w.data = exp_words[k];
            exp_wr.push_back(w);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int count, input bit gap);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            bus.byte_valid = 1'b1;
            bus.byte_in    = 8'(first + i);
            if (gap) begin
                @(negedge clk);
                bus.byte_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] idx, input logic is_err, input logic [31:0] data);
        rd_exp_t r;
        r.is_err = is_err;
        r.data   = data;
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_idx = idx;
        exp_rd.push_back(r);
        @(negedge clk);
        bus.rd_req = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int n;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done_cnt != d0), 64'd1);
        repeat (3) @(negedge clk);
        check("done_pulses",     64'(done_cnt - d0),   64'd1);
        check("loaded_after",    64'(loaded),          64'd1);
        check("busy_after",      64'(busy),            64'd0);
        check("writes_consumed", 64'(exp_wr.size()),   64'd0);
    endtask

    task automatic check_idle_unloaded(input int d0);
        repeat (3) @(negedge clk);
        check("abort_busy",       64'(busy),           64'd0);
        check("abort_byte_ready", 64'(bus.byte_ready), 64'd0);
        check("abort_loaded",     64'(loaded),         64'd0);
        check("abort_no_done",    64'(done_cnt - d0),  64'd0);
        check("abort_writes",     64'(exp_wr.size()),  64'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        fork
            begin : stim
                int d0;

                // Reset values.
                do_reset();

                // Back-to-back full load.
                push_words(10);
                last_wr_cyc = -1;
                exp_spacing = 4;
                d0 = done_cnt;
                pulse_start();
                send_bytes(0, 40, 1'b0);
                wait_done(d0, 30);

                // Same data with a bubble after every byte.
                push_words(10);
                last_wr_cyc = -1;
                exp_spacing = 8;
                d0 = done_cnt;
                pulse_start();
                send_bytes(0, 40, 1'b1);
                wait_done(d0, 30);

                // Read gating after a completed load.
                do_read(4'd9,  1'b0, 32'h27262524);
                do_read(4'd0,  1'b0, 32'h03020100);
                do_read(4'd10, 1'b1, 32'h0);
                do_read(4'd15, 1'b1, 32'h0);

                // Abort together with the last byte of a word: that write is dropped.
                last_wr_cyc = -1;
                d0 = done_cnt;
                pulse_start();
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    bus.byte_valid = 1'b1;
                    bus.byte_in    = 8'(i);
                    abort          = (i == 3);
                end
                @(negedge clk);
                abort          = 1'b0;
                bus.byte_valid = 1'b0;
                check_idle_unloaded(d0);

                // Abort after six bytes: exactly one write.
                push_words(1);
                last_wr_cyc = -1;
                d0 = done_cnt;
                pulse_start();
                send_bytes(0, 6, 1'b0);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_idle_unloaded(d0);
                do_read(4'd0, 1'b1, 32'h0);

                // Start and abort together in IDLE: start wins, and a read mid-load is rejected.
                push_words(10);
                last_wr_cyc = -1;
                exp_spacing = 4;
                d0 = done_cnt;
                @(negedge clk);
                start = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                start = 1'b0;
                abort = 1'b0;
                check("start_wins_busy", 64'(busy), 64'd1);
                do_read(4'd0, 1'b1, 32'h0);
                send_bytes(0, 40, 1'b0);
                wait_done(d0, 30);

                // Reset one cycle after byte 23 completes word 5.
                push_words(6);
                last_wr_cyc = -1;
                exp_spacing = 4;
                d0 = done_cnt;
                pulse_start();
                for (int i = 0; i < 24; i++) begin
                    @(negedge clk);
                    bus.byte_valid = 1'b1;
                    bus.byte_in    = 8'(i);
                end
                @(negedge clk);
                bus.byte_valid = 1'b0;
                rst            = 1'b1;
                @(negedge clk);
                check_reset_outputs();
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("rst_mid_writes",  64'(exp_wr.size()), 64'd0);
                check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);

                // Ignored inputs: bytes in IDLE, start during LOAD, bytes after completion.
                do_reset();
                push_words(10);
                last_wr_cyc = -1;
                exp_spacing = 4;
                d0 = done_cnt;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    bus.byte_valid = 1'b1;
                    bus.byte_in    = 8'hAA;
                end
                bus.byte_in = 8'hEE;
                pulse_start();
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    bus.byte_valid = 1'b1;
                    bus.byte_in    = 8'(i);
                    start          = (i == 10) || (i == 21);
                end
                @(negedge clk);
                bus.byte_valid = 1'b0;
                start          = 1'b0;
                wait_done(d0, 30);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    bus.byte_valid = 1'b1;
                    bus.byte_in    = 8'h55;
                end
                @(negedge clk);
                bus.byte_valid = 1'b0;
                repeat (3) @(negedge clk);
                check("idle_bytes_dropped", 64'(exp_wr.size()), 64'd0);
                check("loaded_kept",        64'(loaded),        64'd1);
                do_read(4'd5, 1'b0, 32'h17161514);
                repeat (2) @(negedge clk);
                check("reads_consumed", 64'(exp_rd.size()), 64'd0);
            end

            begin : mon
                forever begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (!rst && bus.wr_en) begin
                        if (exp_wr.size() == 0) begin
                            check("wr_unexpected", 64'(bus.wr_en), 64'd0);
                        end else begin
                            mw = exp_wr.pop_front();
                            check("wr_addr", 64'(bus.wr_addr), 64'(mw.addr));
                            check("wr_data", 64'(bus.wr_data), 64'(mw.data));
                        end
                        if (exp_spacing != 0 && last_wr_cyc >= 0) begin
                            check("wr_spacing", 64'(cyc - last_wr_cyc), 64'(exp_spacing));
                        end
                        last_wr_cyc = cyc;
                    end
                    if (done) begin
                        done_cnt++;
                        check("done_after_last_wr", 64'(cyc - last_wr_cyc), 64'd1);
                    end
                    if (bus.rd_valid && bus.rd_err) begin
                        check("rd_exclusive", 64'(bus.rd_err), 64'd0);
                    end
                    if (bus.rd_valid || bus.rd_err) begin
                        if (exp_rd.size() == 0) begin
                            check("rd_unexpected", 64'(bus.rd_valid | bus.rd_err), 64'd0);
                        end else begin
                            mr = exp_rd.pop_front();
                            check("rd_err",   64'(bus.rd_err),   64'(mr.is_err));
                            check("rd_valid", 64'(bus.rd_valid), 64'(!mr.is_err));
                            if (!mr.is_err) begin
                                check("rd_data", 64'(ram_rd_data), 64'(mr.data));
                            end
                        end
                    end
                end
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
